udma_i2c_cmd_arbiter: RTL
=========================

// Module: udma_i2c_cmd_arbiter
// PURPOSE
//  Shares the single uDMA I2C command channel between NB_REQ 32-bit command streams.
//  Grants whole I2C transactions atomically: an owner keeps the channel from its first accepted command
//  until it issues STOP or EOT, so no other master's commands interleave between START and STOP.
//  Sits in sys clock domain, upstream of the command dual-clock FIFO feeding the I2C control FSM.
//  Exports owner id so RX data/eot routing outside this block can follow the active transaction.
// PARAMETERS
//  NB_REQ  2   number of requesters (>=2); ID_W = $clog2(NB_REQ)
//  CMD_W   32  command word width; opcode in [CMD_W-1:CMD_W-4]
//  TO_W    16  width of stall-timeout counter and cfg_timeout_i
// PORTS
//  clk_i          in   1              clock
//  rst_i          in   1              synchronous, active-high reset
//  abort_i        in   1              synchronous release of the lock (sw flush), no error flagged
//  cfg_timeout_i  in   TO_W           owner-stall limit in cycles; 0 = timeout disabled
//  req_cmd_i      in   NB_REQ*CMD_W   command word per requester (slice i = requester i)
//  req_valid_i    in   NB_REQ         command valid per requester
//  req_ready_o    out  NB_REQ         command ready per requester
//  cmd_o          out  CMD_W          forwarded command
//  cmd_valid_o    out  1              forwarded valid
//  cmd_ready_i    in   1              downstream ready
//  busy_o         out  1              channel locked
//  owner_o        out  ID_W           current/last owner id
//  done_o         out  NB_REQ         1-cycle pulse: owner i released the lock normally (STOP/EOT)
//  timeout_o      out  1              1-cycle pulse: lock forcibly released on owner stall
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, owner_o 0, counter 0. All outputs 0: req_ready_o, cmd_valid_o,
//   busy_o, done_o, timeout_o, cmd_o.
//  FSM IDLE / LOCKED.
//  IDLE:
//   - cmd_valid_o=0 and req_ready_o=0.
//   - If any req_valid_i: owner = first valid requester at or after rr pointer (wrapping mod NB_REQ);
//     go LOCKED next cycle.
//   - Arbitration latency 1 cycle, so the first command is forwarded no earlier than the cycle after
//     valid rises.
//  LOCKED:
//   - Combinational pass-through of owner only: cmd_o=req_cmd_i[owner]; cmd_valid_o=req_valid_i[owner];
//     req_ready_o[owner]=cmd_ready_i; all other req_ready_o=0.
//   - cmd_o=0 whenever cmd_valid_o=0.
//   - Release when a command with opcode STOP or EOT handshakes (valid&ready): next state IDLE,
//     done_o[owner] pulses that cycle, rr pointer = owner+1 (wrap to 0 after NB_REQ-1).
//   - Back-to-back: a different requester may be granted in the IDLE cycle that follows; the same
//     requester loses priority to any other pending requester.
//  Timeout:
//   - Counter clears on every owner handshake and on LOCKED entry.
//   - Counter increments each LOCKED cycle where req_valid_i[owner]=0. Downstream backpressure
//     (valid=1, ready=0) does not count.
//   - When counter reaches cfg_timeout_i (!=0): go IDLE, timeout_o pulses, rr pointer = owner+1,
//     no done_o.
//   - Counter saturates at all-ones; it never wraps.
//  Simultaneous events:
//   - STOP/EOT handshake in the same cycle as timeout expiry: normal release (done_o, no timeout_o).
//   - abort_i has priority over both: IDLE next cycle; no done_o or timeout_o; the current cycle's
//     handshake still completes.
//  Reset mid-transaction: immediate return to reset state; any in-flight command not handshaken is
//   dropped from this block's view.
//  busy_o=1 exactly in LOCKED. owner_o holds its value after release until the next grant.
//  Opcode decode uses only [CMD_W-1:CMD_W-4]; lower bits are passed through untouched.
// STRUCTURE
//  Shared pkg udma_i2c_pkg holds:
//   - the 4-bit command opcode constants (I2C_CMD_START=4'h0, I2C_CMD_STOP=4'h2, I2C_CMD_EOT=4'h9,
//     plus the remaining opcodes);
//   - the arb_state_e {IDLE, LOCKED} typedef.
//  One sub-module: udma_i2c_rr_pick #(NB_REQ). Combinational round-robin priority select:
//   req vector + pointer -> one-hot grant + id. Reusable for a future RX/TX data arbiter.
// TESTING
//  1. NB_REQ=2, req0 sends START,WR,STOP; req1 asserts valid on the same cycle -> req0 granted first.
//     All 3 commands out contiguous; done_o[0] on the STOP handshake; req1 granted the next IDLE cycle.
//  2. Both requesters continuously valid, 4 transactions each -> owner_o alternates 0,1,0,1.
//     No command of one transaction appears between the START and STOP of another.
//  3. cfg_timeout_i=8, req1 stalls after START -> timeout_o pulses 8 cycles after the last handshake;
//     req0 granted next; no done_o[1].
//  4. cmd_ready_i held 0 for 50 cycles while owner valid, cfg_timeout_i=8 -> no timeout; commands
//     resume unchanged when ready returns.
//  5. abort_i asserted mid-transaction and on the same cycle as STOP handshake -> IDLE next cycle;
//     no done_o/timeout_o; the STOP is forwarded exactly once.
//  6. rst_i pulsed while LOCKED with valid high -> next cycle all outputs 0, rr pointer 0;
//     requester 0 wins a subsequent tie.

Source files
------------

// File: rtl/udma_i2c_pkg.sv
// Shared definitions for the uDMA I2C command path: the 4-bit opcode set carried in the
// top nibble of each command word, and the command-arbiter state type.
package udma_i2c_pkg;

  localparam logic [3:0] I2C_CMD_START   = 4'h0;
  localparam logic [3:0] I2C_CMD_WAIT    = 4'h1;
  localparam logic [3:0] I2C_CMD_STOP    = 4'h2;
  localparam logic [3:0] I2C_CMD_RD_ACK  = 4'h4;
  localparam logic [3:0] I2C_CMD_RD_NACK = 4'h6;
  localparam logic [3:0] I2C_CMD_WR      = 4'h8;
  localparam logic [3:0] I2C_CMD_EOT     = 4'h9;
  localparam logic [3:0] I2C_CMD_WAIT_EV = 4'hA;
  localparam logic [3:0] I2C_CMD_RPT     = 4'hC;
  localparam logic [3:0] I2C_CMD_CFG     = 4'hE;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Opcodes that end a bus transaction and therefore release the channel lock.
  function automatic logic is_release_op(input logic [3:0] op);
    return (op == I2C_CMD_STOP) || (op == I2C_CMD_EOT);
  endfunction

endpackage

// File: rtl/udma_i2c_rr_pick.sv
// Combinational round-robin select: picks the first asserted request at or after ptr,
// wrapping modulo NB_REQ, and returns it both one-hot and as an index.
module udma_i2c_rr_pick #(
  parameter int unsigned NB_REQ = 2,
  localparam int unsigned ID_W  = $clog2(NB_REQ)
) (
  input  logic [NB_REQ-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic [NB_REQ-1:0] gnt,
  output logic [ID_W-1:0]   id
);

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt   = '0;
    id    = '0;
    idx   = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      idx = (32'(ptr) + k) % NB_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        id       = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/udma_i2c_cmd_arbiter.sv
// Shares the uDMA I2C command channel between NB_REQ requesters, granting whole
// START..STOP/EOT transactions atomically with a stall timeout and a software abort.
module udma_i2c_cmd_arbiter
  import udma_i2c_pkg::*;
#(
  parameter int unsigned NB_REQ = 2,
  parameter int unsigned CMD_W  = 32,
  parameter int unsigned TO_W   = 16,
  localparam int unsigned ID_W  = $clog2(NB_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    abort_i,
  input  logic [TO_W-1:0]         cfg_timeout_i,
  input  logic [NB_REQ*CMD_W-1:0] req_cmd_i,
  input  logic [NB_REQ-1:0]       req_valid_i,
  output logic [NB_REQ-1:0]       req_ready_o,
  output logic [CMD_W-1:0]        cmd_o,
  output logic                    cmd_valid_o,
  input  logic                    cmd_ready_i,
  output logic                    busy_o,
  output logic [ID_W-1:0]         owner_o,
  output logic [NB_REQ-1:0]       done_o,
  output logic                    timeout_o
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic [NB_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]   pick_id;
  logic              pick_any;

  logic [CMD_W-1:0] own_cmd;
  logic             own_valid;
  logic             locked;
  logic             hs;
  logic             rel;
  logic             stall;
  logic [TO_W-1:0]  cnt_inc;
  logic [TO_W-1:0]  cnt_nxt;
  logic             expire;
  logic [ID_W-1:0]  ptr_after_owner;

  udma_i2c_rr_pick #(
    .NB_REQ (NB_REQ)
  ) u_rr_pick (
    .req (req_valid_i),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .id  (pick_id)
  );

  assign pick_any = |pick_gnt;

  assign locked    = (state_q == LOCKED);
  assign own_cmd   = req_cmd_i[CMD_W*32'(owner_q) +: CMD_W];
  assign own_valid = req_valid_i[owner_q];
  assign hs        = locked && own_valid && cmd_ready_i;
  assign rel       = hs && is_release_op(own_cmd[CMD_W-1 -: 4]);
  // Only an absent owner counts as a stall; downstream backpressure never does.
  assign stall     = locked && !own_valid;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign cnt_nxt = hs ? '0 : (stall ? cnt_inc : cnt_q);
  // A normal release in the same cycle wins over expiry.
  assign expire  = locked && !rel && (cfg_timeout_i != '0) && (cnt_nxt >= cfg_timeout_i);

  assign ptr_after_owner = (owner_q == ID_W'(NB_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    cmd_o       = '0;
    cmd_valid_o = 1'b0;
    req_ready_o = '0;
    done_o      = '0;
    timeout_o   = 1'b0;
    busy_o      = locked;
    owner_o     = owner_q;
    if (locked) begin
      cmd_valid_o          = own_valid;
      cmd_o                = own_valid ? own_cmd : '0;
      req_ready_o[owner_q] = cmd_ready_i;
      done_o[owner_q]      = rel && !abort_i;
      timeout_o            = expire && !abort_i;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!abort_i && pick_any) begin
          state_d = LOCKED;
          owner_d = pick_id;
        end
      end
      LOCKED: begin
        cnt_d = cnt_nxt;
        if (abort_i) begin
          state_d = IDLE;
        end else if (rel || expire) begin
          state_d = IDLE;
          ptr_d   = ptr_after_owner;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
